// File: rtl/bus_pkg.sv
// Shared definitions for the two-master RAM bus: state encodings and bus width.
package bus_pkg;

  localparam int BUS_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter2_if.sv
// Request/grant and slave-side bus signals shared by two masters and the arbiter.
interface bus_arbiter2_if;
  import bus_pkg::*;

  logic             m0_req;
  logic             m0_wr;
  logic [BUS_W-1:0] m0_addr;
  logic [BUS_W-1:0] m0_dout;
  logic             m1_req;
  logic             m1_wr;
  logic [BUS_W-1:0] m1_addr;
  logic [BUS_W-1:0] m1_dout;
  logic             m0_grant;
  logic             m1_grant;
  logic             s_sel;
  logic             s_wr;
  logic [BUS_W-1:0] s_addr;
  logic [BUS_W-1:0] s_din;

  // Master side drives requests and data, observes grants and the slave bus.
  modport master (
    output m0_req, m0_wr, m0_addr, m0_dout,
    output m1_req, m1_wr, m1_addr, m1_dout,
    input  m0_grant, m1_grant, s_sel, s_wr, s_addr, s_din
  );

  // Arbiter side consumes requests and drives grants and the slave bus.
  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_dout,
    input  m1_req, m1_wr, m1_addr, m1_dout,
    output m0_grant, m1_grant, s_sel, s_wr, s_addr, s_din
  );

endinterface

// File: rtl/mux2_32bits.sv
// 2:1 bus-width multiplexer used to steer address and write data onto the slave.
module mux2_32bits
  import bus_pkg::*;
(
  input  logic [BUS_W-1:0] d0,
  input  logic [BUS_W-1:0] d1,
  input  logic             s,
  output logic [BUS_W-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/bus_arbiter2.sv
// Round-robin arbiter for two masters sharing the RAM bus, with an optional
// hold limit that forces rotation when the other master is waiting.
module bus_arbiter2
  import bus_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter2_if.slave bus
);

  // With MAX_HOLD == 0 the counter simply sits at zero and rotation never fires.
  localparam logic [CNT_W-1:0] HOLD_LIM = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic             ROT_EN   = (MAX_HOLD != 0);

  arb_state_t       state, next_state;
  logic [CNT_W-1:0] hold_cnt, next_cnt;
  logic             last, next_last;
  logic             m0_grant_r, m1_grant_r, s_sel_r;
  logic             own_req, oth_req, rot_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == HOLD_LIM) ? c : c + 1'b1;
  endfunction

  always_comb begin
    next_state = state;
    next_cnt   = '0;
    next_last  = last;
    own_req    = (state == GRANT1) ? bus.m1_req : bus.m0_req;
    oth_req    = (state == GRANT1) ? bus.m0_req : bus.m1_req;
    rot_hit    = ROT_EN && oth_req && (hold_cnt == HOLD_LIM);

    case (state)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) next_state = last ? GRANT0 : GRANT1;
        else if (bus.m0_req)          next_state = GRANT0;
        else if (bus.m1_req)          next_state = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (own_req && !rot_hit) begin
          next_cnt = sat_inc(hold_cnt);
        end else if (oth_req) begin
          next_state = (state == GRANT0) ? GRANT1 : GRANT0;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase

    if (next_state == GRANT0)      next_last = 1'b0;
    else if (next_state == GRANT1) next_last = 1'b1;
  end

  // Grant and select are registered from the next state so they change only on edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last       <= 1'b1;
      m0_grant_r <= 1'b0;
      m1_grant_r <= 1'b0;
      s_sel_r    <= 1'b0;
    end else begin
      state      <= next_state;
      hold_cnt   <= next_cnt;
      last       <= next_last;
      m0_grant_r <= (next_state == GRANT0);
      m1_grant_r <= (next_state == GRANT1);
      s_sel_r    <= (next_state == GRANT1);
    end
  end

  assign bus.m0_grant = m0_grant_r;
  assign bus.m1_grant = m1_grant_r;
  assign bus.s_sel    = s_sel_r;
  assign bus.s_wr     = ~reset & ((m0_grant_r & bus.m0_wr) | (m1_grant_r & bus.m1_wr));

  mux2_32bits u_addr_mux (
    .d0 (bus.m0_addr),
    .d1 (bus.m1_addr),
    .s  (s_sel_r),
    .y  (bus.s_addr)
  );

  mux2_32bits u_data_mux (
    .d0 (bus.m0_dout),
    .d1 (bus.m1_dout),
    .s  (s_sel_r),
    .y  (bus.s_din)
  );

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2 with MAX_HOLD=4.
module tb_bus_arbiter2;
  import bus_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  bus_arbiter2_if bif ();

  bus_arbiter2 #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later, and confirm the grants stay exclusive.
  task automatic step();
    @(posedge clk);
    #1;
    chk("grant_excl", 32'(bif.m0_grant & bif.m1_grant), 32'd0);
  endtask

  task automatic chk_grants(input string tag, input logic g0, input logic g1, input logic sel);
    chk({tag, "_g0"}, 32'(bif.m0_grant), 32'(g0));
    chk({tag, "_g1"}, 32'(bif.m1_grant), 32'(g1));
    chk({tag, "_sel"}, 32'(bif.s_sel), 32'(sel));
  endtask

  initial begin
    reset       = 1'b1;
    bif.m0_req  = 1'b1;
    bif.m1_req  = 1'b1;
    bif.m0_wr   = 1'b1;
    bif.m1_wr   = 1'b1;
    bif.m0_addr = 32'h0000_0004;
    bif.m0_dout = 32'h5555_5555;
    bif.m1_addr = 32'h0000_0010;
    bif.m1_dout = 32'hAAAA_AAAA;

    // Reset with both requesting
    step();
    step();
    chk_grants("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_swr", 32'(bif.s_wr), 32'd0);
    reset = 1'b0;
    step();
    chk_grants("first", 1'b1, 1'b0, 1'b0);

    // Release both -> idle
    bif.m0_req = 1'b0;
    bif.m1_req = 1'b0;
    step();
    chk_grants("idle1", 1'b0, 1'b0, 1'b0);

    // Only master 1 requests, master 0 strobes write without request
    bif.m1_req = 1'b1;
    step();
    chk_grants("m1only", 1'b0, 1'b1, 1'b1);
    chk("m1only_addr", bif.s_addr, 32'h0000_0010);
    chk("m1only_din", bif.s_din, 32'hAAAA_AAAA);
    chk("m1only_swr", 32'(bif.s_wr), 32'd1);
    bif.m1_wr = 1'b0;
    step();
    chk("m0wr_blocked", 32'(bif.s_wr), 32'd0);
    chk("m1_hold", 32'(bif.m1_grant), 32'd1);

    // Forced rotation: m0 holds, m1 arrives in m0's first grant cycle
    bif.m1_req = 1'b0;
    bif.m0_wr  = 1'b0;
    step();
    chk_grants("idle2", 1'b0, 1'b0, 1'b0);
    bif.m0_req = 1'b1;
    step();
    chk_grants("rot_c1", 1'b1, 1'b0, 1'b0);
    bif.m1_req = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      step();
      chk_grants($sformatf("rot_c%0d", i), 1'b1, 1'b0, 1'b0);
    end
    step();
    chk_grants("rot_to_m1", 1'b0, 1'b1, 1'b1);
    bif.m1_req = 1'b0;
    step();
    chk_grants("rot_back_m0", 1'b1, 1'b0, 1'b0);

    // Back-to-back handoff without an idle bubble
    bif.m0_req = 1'b0;
    bif.m1_req = 1'b1;
    step();
    chk_grants("handoff", 1'b0, 1'b1, 1'b1);
    step();
    step();
    chk_grants("m1_keep", 1'b0, 1'b1, 1'b1);

    // Both idle: bus parks on master 0 and never writes
    bif.m1_req  = 1'b0;
    bif.m0_addr = 32'hFFFF_FFFF;
    bif.m0_wr   = 1'b1;
    step();
    chk_grants("park", 1'b0, 1'b0, 1'b0);
    chk("park_addr", bif.s_addr, 32'hFFFF_FFFF);
    chk("park_swr", 32'(bif.s_wr), 32'd0);

    // Fresh full window on the next contended grant (last was master 1)
    bif.m0_req = 1'b1;
    bif.m1_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_grants($sformatf("win_c%0d", i), 1'b1, 1'b0, 1'b0);
    end
    step();
    chk_grants("win_to_m1", 1'b0, 1'b1, 1'b1);

    // Reset during an active master 1 write
    bif.m1_wr = 1'b1;
    #1;
    chk("g1_write", 32'(bif.s_wr), 32'd1);
    reset = 1'b1;
    step();
    chk_grants("midrst", 1'b0, 1'b0, 1'b0);
    chk("midrst_swr", 32'(bif.s_wr), 32'd0);
    reset = 1'b0;
    step();
    chk_grants("post_rst", 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
